// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: byte-in / key-event-out bundle between a PS/2 receiver and the key decoder
// Signals: ps2_key_pressed/ps2_key_data carry a strobed received byte into the decoder;
//   key_event_* report decoded make/break events; *_held are key-down levels;
//   jump_pulse and protocol_error are one-cycle pulses.
// Modports: master drives bytes and observes events, slave is the decoder side.
interface ps2_key_decoder_if;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;
  logic       key_event_valid;
  logic [7:0] key_event_code;
  logic       key_event_ext;
  logic       key_event_break;
  logic       space_held;
  logic       up_held;
  logic       esc_held;
  logic       enter_held;
  logic       jump_pulse;
  logic       protocol_error;
  modport master (
    output ps2_key_pressed, ps2_key_data,
    input  key_event_valid, key_event_code, key_event_ext, key_event_break,
    input  space_held, up_held, esc_held, enter_held, jump_pulse, protocol_error
  );
  modport slave (
    input  ps2_key_pressed, ps2_key_data,
    output key_event_valid, key_event_code, key_event_ext, key_event_break,
    output space_held, up_held, esc_held, enter_held, jump_pulse, protocol_error
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns a PS/2 set-2 scancode byte stream into make/break key events
// Ports: CLOCK_50 clock (rising edge), reset synchronous active-high,
//   bus (ps2_key_decoder_if.slave): byte strobe/data in; event, held-key, jump and error out.
// Parameters: PREFIX_TIMEOUT cycles a partial prefix may wait, PAUSE_SKIP bytes dropped after E1.
// Define PS2_TYPEMATIC_FILTER_EN to drop make events that repeat the last make {ext,code}.
module ps2_key_decoder #(
  parameter int PREFIX_TIMEOUT = 1000000,
  parameter int PAUSE_SKIP = 7
) (
  input logic CLOCK_50,
  input logic reset,
  ps2_key_decoder_if.slave bus
);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam int SW = $clog2(PAUSE_SKIP + 1);
  localparam logic [8:0] SPACE = 9'h029, UP = 9'h175, ESC = 9'h076, ENTER = 9'h05A;
  localparam logic [8:0] HELD_KEYS [4] = '{SPACE, UP, ESC, ENTER};
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [3:0] held_q, held_d;
  logic [7:0] b, code_q;
  logic [8:0] key;
  logic stb, pfx, ign, expire, ev_make, ev_brk, filt, emit, jump, err;
  logic valid_q, ext_q, brk_q, jump_q, err_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_q;
`endif
  assign stb = bus.ps2_key_pressed;
  assign b = bus.ps2_key_data;
  assign pfx = b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
  assign ign = b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  // a byte arriving on the expiry cycle wins, so expiry needs a strobe-free cycle
  assign expire = state_q != IDLE && !stb && tmo_q == TW'(PREFIX_TIMEOUT - 1);
  assign tmo_d = state_q == IDLE || stb || expire ? '0 : tmo_q + 1'b1;
  assign skip_d = state_q == SKIP ? skip_q + SW'(stb) : '0;

  always_ff @(posedge CLOCK_50) state_q <= reset ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    if (expire) state_d = IDLE;
    else if (stb)
      case (state_q)
        IDLE:    state_d = b == 8'hE0 ? EXT : b == 8'hF0 ? BRK : b == 8'hE1 ? SKIP : IDLE;
        EXT:     state_d = b == 8'hE0 ? EXT : b == 8'hF0 ? EXT_BRK : IDLE;
        SKIP:    state_d = skip_q == SW'(PAUSE_SKIP - 1) ? IDLE : SKIP;
        default: state_d = IDLE;
      endcase
  end

  always_comb begin
    key = {state_q == EXT || state_q == EXT_BRK, b};
    ev_make = stb && (state_q == IDLE ? !pfx && !ign
                                      : state_q == EXT && b != 8'hE0 && b != 8'hF0 && b != 8'h12);
    ev_brk = stb && !pfx && (state_q == BRK || (state_q == EXT_BRK && b != 8'h12));
    err = (expire && state_q != SKIP) || (stb && pfx && (state_q == BRK || state_q == EXT_BRK));
`ifdef PS2_TYPEMATIC_FILTER_EN
    filt = ev_make && key == last_q;
`else
    filt = 1'b0;
`endif
    emit = ev_brk || (ev_make && !filt);
    jump = ev_make && !filt && (key == SPACE || key == UP) && !held_q[0] && !held_q[1];
    held_d = held_q;
    for (int i = 0; i < 4; i++)
      if (key == HELD_KEYS[i] && (ev_make || ev_brk)) held_d[i] = ev_make;
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  always_ff @(posedge CLOCK_50) last_q <= reset || ev_brk ? '0 : ev_make ? key : last_q;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tmo_q <= '0;
      skip_q <= '0;
      held_q <= '0;
      valid_q <= 1'b0;
      jump_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= 8'h00;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      skip_q <= skip_d;
      held_q <= held_d;
      valid_q <= emit;
      jump_q <= jump;
      err_q <= err;
      if (emit) begin
        code_q <= b;
        ext_q <= key[8];
        brk_q <= ev_brk;
      end
    end
  end

  assign bus.key_event_valid = valid_q;
  assign bus.key_event_code = code_q;
  assign bus.key_event_ext = ext_q;
  assign bus.key_event_break = brk_q;
  assign bus.space_held = held_q[0];
  assign bus.up_held = held_q[1];
  assign bus.esc_held = held_q[2];
  assign bus.enter_held = held_q[3];
  assign bus.jump_pulse = jump_q;
  assign bus.protocol_error = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and random byte streams checked against a sequence-level model
module tb_ps2_key_decoder;
  localparam int T = 20, PS = 7;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int REPEAT_EVENTS = 1;
`else
  localparam int REPEAT_EVENTS = 3;
`endif
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  ps2_key_decoder_if bus ();
  ps2_key_decoder #(.PREFIX_TIMEOUT(T), .PAUSE_SKIP(PS)) dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0, n_bad = 0;
  int ev_cnt = 0, jump_cnt = 0, err_cnt = 0;
  logic [7:0] pfx [$];
  int skip_left = 0, cyc = 0, last_byte_cyc = 0;
  logic [8:0] m_last = '0;
  logic [3:0] m_held = '0;
  logic e_valid, e_ext, e_brk, e_jump, e_err;
  logic [7:0] e_code;
  logic [7:0] pool [12] = '{8'h29, 8'h75, 8'h76, 8'h5A, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h12, 8'hAA, 8'h00};

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int key_idx(logic [8:0] k);
    return k == 9'h029 ? 0 : k == 9'h175 ? 1 : k == 9'h076 ? 2 : k == 9'h05A ? 3 : -1;
  endfunction

  task automatic m_event(bit ext, bit brk, logic [7:0] c);
    logic [8:0] k = {ext, c};
    int i = key_idx(k);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (!brk && k == m_last) return;
`endif
    if (!brk) begin
      e_jump = (k == 9'h029 || k == 9'h175) && !m_held[0] && !m_held[1];
      if (i >= 0) m_held[i] = 1'b1;
      m_last = k;
    end else begin
      if (i >= 0) m_held[i] = 1'b0;
      m_last = '0;
    end
    e_valid = 1'b1;
    e_code = c;
    e_ext = ext;
    e_brk = brk;
  endtask

  task automatic m_byte(logic [7:0] b);
    bit is_p = b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
    bit ext;
    if (skip_left > 0) skip_left--;
    else if (pfx.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
      else if (b == 8'hE1) skip_left = PS;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) m_event(1'b0, 1'b0, b);
    end else if (pfx[$] == 8'hE0) begin
      if (b == 8'hF0) pfx.push_back(b);
      else if (b != 8'hE0) begin
        pfx.delete();
        if (b != 8'h12) m_event(1'b1, 1'b0, b);
      end
    end else begin
      ext = pfx[0] == 8'hE0;
      pfx.delete();
      if (is_p) e_err = 1'b1;
      else if (!(ext && b == 8'h12)) m_event(ext, 1'b1, b);
    end
  endtask

  task automatic m_step(bit stb, logic [7:0] b);
    e_valid = 1'b0;
    e_jump = 1'b0;
    e_err = 1'b0;
    if (stb) begin
      last_byte_cyc = cyc;
      m_byte(b);
    end else if ((pfx.size() > 0 || skip_left > 0) && cyc - last_byte_cyc == T) begin
      e_err = pfx.size() > 0;
      pfx.delete();
      skip_left = 0;
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("valid", 9'(bus.key_event_valid), 9'(e_valid));
    chk("code", 9'(bus.key_event_code), 9'(e_code));
    chk("ext", 9'(bus.key_event_ext), 9'(e_ext));
    chk("break", 9'(bus.key_event_break), 9'(e_brk));
    chk("jump", 9'(bus.jump_pulse), 9'(e_jump));
    chk("error", 9'(bus.protocol_error), 9'(e_err));
    chk("held", 9'({bus.enter_held, bus.esc_held, bus.up_held, bus.space_held}), 9'(m_held));
    ev_cnt += int'(bus.key_event_valid === 1'b1);
    jump_cnt += int'(bus.jump_pulse === 1'b1);
    err_cnt += int'(bus.protocol_error === 1'b1);
  endtask

  task automatic cycle(bit stb, logic [7:0] b);
    bus.ps2_key_pressed = stb;
    bus.ps2_key_data = stb ? b : 8'($urandom);
    m_step(stb, b);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_all();
  endtask

  task automatic send(logic [7:0] b, int gap);
    cycle(1'b1, b);
    repeat (gap) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_key_data = 8'h00;
    repeat (n) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
    end
    pfx.delete();
    skip_left = 0;
    m_held = '0;
    m_last = '0;
    {e_valid, e_ext, e_brk, e_jump, e_err, e_code} = '0;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int e0, j0, r0;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_key_data = 8'h00;
    @(negedge CLOCK_50);
    do_reset(2);
    chk("reset_code", 9'(bus.key_event_code), 9'h000);
    // space press/release
    send(8'h29, 1);
    chk("space_down", 9'(bus.space_held), 9'h1);
    send(8'hF0, 0);
    send(8'h29, 1);
    chk("space_up", 9'(bus.space_held), 9'h0);
    // extended up arrow
    j0 = jump_cnt;
    send(8'hE0, 0);
    send(8'h75, 0);
    chk("up_down", 9'(bus.up_held), 9'h1);
    chk("up_jump", 9'(jump_cnt - j0), 9'h1);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 1);
    chk("up_up", 9'(bus.up_held), 9'h0);
    // typematic repeat
    e0 = ev_cnt;
    j0 = jump_cnt;
    repeat (3) send(8'h29, 0);
    chk("repeat_events", 9'(ev_cnt - e0), 9'(REPEAT_EVENTS));
    chk("repeat_jumps", 9'(jump_cnt - j0), 9'h1);
    send(8'hF0, 0);
    send(8'h29, 1);
    // prefix timeout, then plain esc
    r0 = err_cnt;
    send(8'hE0, 0);
    repeat (T) cycle(1'b0, 8'h00);
    chk("timeout_err", 9'(err_cnt - r0), 9'h1);
    send(8'h76, 1);
    chk("esc_down", 9'(bus.esc_held), 9'h1);
    // byte on the expiry cycle wins
    r0 = err_cnt;
    send(8'hE0, 0);
    repeat (T - 1) cycle(1'b0, 8'h00);
    send(8'h75, 1);
    chk("edge_no_err", 9'(err_cnt - r0), 9'h0);
    chk("edge_up", 9'(bus.up_held), 9'h1);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 1);
    // pause sequence then enter
    e0 = ev_cnt;
    send(8'hE1, 0);
    send(8'h14, 0);
    send(8'h77, 0);
    send(8'hE1, 0);
    send(8'hF0, 0);
    send(8'h14, 0);
    send(8'hF0, 0);
    send(8'h77, 0);
    chk("pause_silent", 9'(ev_cnt - e0), 9'h0);
    send(8'h5A, 1);
    chk("enter_down", 9'(bus.enter_held), 9'h1);
    // reset mid-prefix
    r0 = err_cnt;
    send(8'hF0, 0);
    do_reset(1);
    send(8'h29, 1);
    chk("rst_no_err", 9'(err_cnt - r0), 9'h0);
    chk("rst_make", 9'({bus.key_event_break, bus.key_event_code}), 9'h029);
    // random stream
    repeat (500) begin
      int r = $urandom_range(0, 99);
      if (r < 2) do_reset(1);
      else if (r < 6) repeat (T + $urandom_range(0, 2)) cycle(1'b0, 8'h00);
      else if (r < 60) cycle(1'b1, r < 12 ? 8'($urandom) : pool[$urandom_range(0, 11)]);
      else cycle(1'b0, 8'h00);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter PREFIX_TIMEOUT, default 1000000, meaning CLOCK_50 cycles a partial prefix sequence may wait for its next byte (20 ms).
REQ-002 SHALL have parameter PAUSE_SKIP, default 7, meaning the number of bytes discarded after an E1 (Pause) lead byte.
REQ-003 SHALL have port CLOCK_50 input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 SHALL have port ps2_key_pressed input 1: one-cycle strobe marking a valid received byte.
REQ-006 SHALL have port ps2_key_data input 8: the received byte, valid when the strobe is high.
REQ-007 SHALL have port key_event_valid output 1: one-cycle pulse per decoded key event.
REQ-008 SHALL have port key_event_code output 8: scancode of the event, held until the next event.
REQ-009 SHALL have port key_event_ext output 1: the event carried an E0 prefix.
REQ-010 SHALL have port key_event_break output 1: the event is a release (1) or a press (0).
REQ-011 SHALL have ports space_held, up_held, esc_held, enter_held output 1 each: level, key currently down.
REQ-012 SHALL have port jump_pulse output 1: one-cycle pulse on a press edge of Space or Up.
REQ-013 SHALL have port protocol_error output 1: one-cycle pulse on an illegal sequence or a timeout.

Function
REQ-014 SHALL use states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen) and SKIP (Pause bytes).
REQ-015 In IDLE, SHALL handle bytes as follows: E0 goes to EXT; F0 goes to BRK; E1 goes to SKIP; 00, AA, EE, FA, FE and FF are ignored; any other byte emits a make event with ext=0.
REQ-016 In EXT, SHALL handle bytes as follows: F0 goes to EXT_BRK; 12 is discarded and goes to IDLE; E0 stays in EXT; any other byte emits a make event with ext=1 and goes to IDLE.
REQ-017 In BRK, a non-prefix byte SHALL emit a break event with ext=0 and go to IDLE; E0, F0 or E1 SHALL pulse protocol_error and go to IDLE.
REQ-018 In EXT_BRK, byte 12 SHALL be discarded; any other non-prefix byte SHALL emit a break event with ext=1; a prefix byte SHALL pulse protocol_error; every case goes to IDLE.
REQ-019 In SKIP, SHALL discard PAUSE_SKIP bytes, then return to IDLE, without emitting events or errors.
REQ-020 Event outputs SHALL register on the cycle after the strobe (latency 1); back-to-back strobes on consecutive cycles SHALL each be processed.
REQ-021 In any state other than IDLE, a timeout counter SHALL run; if it reaches PREFIX_TIMEOUT with no strobe, the block SHALL pulse protocol_error and go to IDLE; SKIP timeout SHALL not pulse protocol_error.
REQ-022 If a strobe arrives in the same cycle as timeout expiry, the byte SHALL win: it is decoded in the current state and the counter is cleared.
REQ-023 SHALL track these held keys: space_held for {ext0,29}; up_held for {ext1,75}; esc_held for {ext0,76}; enter_held for {ext0,5A}. A make event sets the flag; the matching break clears it.
REQ-024 jump_pulse SHALL assert on the same cycle as key_event_valid, for a make of Space or Up while neither was already held.
REQ-025 A break for a key not currently held SHALL still emit its event and SHALL leave the flags unchanged.

Reset
REQ-026 While reset is high, SHALL set state to IDLE and clear the timeout counter, skip counter and last-make register.
REQ-027 While reset is high, SHALL drive all outputs to 0 and key_event_code to 8'h00.
REQ-028 Reset mid-sequence SHALL drop the partial prefix silently, with no event and no error.

Configuration
REQ-029 With PS2_TYPEMATIC_FILTER_EN defined, SHALL keep a 9-bit last-make register {ext,code}.
REQ-030 With PS2_TYPEMATIC_FILTER_EN defined, a make equal to last-make SHALL produce no key_event_valid and no jump_pulse.
REQ-031 With PS2_TYPEMATIC_FILTER_EN defined, any break event SHALL clear last-make.
REQ-032 Without PS2_TYPEMATIC_FILTER_EN, every typematic repeat SHALL emit a make event; jump_pulse still fires only on the held edge.

Verification
REQ-033 Bytes 29, F0, 29 -> make {0,29}, jump_pulse=1, space_held=1; then break {0,29}, space_held=0.
REQ-034 Bytes E0, 75, E0, F0, 75 -> make ext=1 code 75, up_held=1, jump_pulse=1; then break ext=1, up_held=0.
REQ-035 Bytes 29, 29, 29 -> filter defined: exactly one event; filter undefined: three events and one jump_pulse.
REQ-036 Byte E0 then idle for PREFIX_TIMEOUT cycles -> protocol_error pulse; then byte 76 -> make {0,76}, esc_held=1.
REQ-037 Bytes E1, 14, 77, E1, F0, 14, F0, 77, then 5A -> no events during Pause; then make {0,5A}, enter_held=1.
REQ-038 Bytes F0, then reset for 1 cycle, then 29 -> no error, no break; make {0,29} emitted.
